// File: rtl/hazard_stall_unit_if.sv
// Handshake bundle between the pipeline datapath and the hazard stall unit.
// Carries ID/EX hazard sources in and stall/flush controls out.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_Ra;
  logic [4:0]       id_Rb;
  logic             id_useRa;
  logic             id_useRb;
  logic [4:0]       ex_Rw;
  logic             ex_RegWr;
  logic             ex_MemRead;
  logic             ex_branchTaken;
  logic             ex_mdStart;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_Ra, id_Rb, id_useRa, id_useRb,
    output ex_Rw, ex_RegWr, ex_MemRead,
    output ex_branchTaken, ex_mdStart,
    input  pc_stall, ifid_stall, ifid_flush,
    input  idex_stall, idex_flush, exmem_flush,
    input  md_busy, stall_cnt
  );

  modport slave (
    input  id_Ra, id_Rb, id_useRa, id_useRb,
    input  ex_Rw, ex_RegWr, ex_MemRead,
    input  ex_branchTaken, ex_mdStart,
    output pc_stall, ifid_stall, ifid_flush,
    output idex_stall, idex_flush, exmem_flush,
    output md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for load-use, taken branch and mul/div occupancy.
// Mul/div FSM is built only when PCPU_MULDIV_STALL_EN is defined.
module hazard_stall_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_unit_if.slave hs
);

  logic rs_a_hit;
  logic rs_b_hit;
  logic load_use;
  logic md_stall;

  assign rs_a_hit = hs.id_useRa
                 && (hs.id_Ra == hs.ex_Rw);
  assign rs_b_hit = hs.id_useRb
                 && (hs.id_Rb == hs.ex_Rw);

  assign load_use = hs.ex_MemRead
                 && hs.ex_RegWr
                 && (hs.ex_Rw != 5'd0)
                 && (rs_a_hit || rs_b_hit);

`ifdef PCPU_MULDIV_STALL_EN
  localparam int MD_CW =
    (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MD_CW-1:0] MD_LOAD =
    MD_CW'(MD_LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    MD_BUSY,
    MD_DONE
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [MD_CW-1:0] md_cnt_q;
  logic [MD_CW-1:0] md_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // The start cycle stalls too, so the counter loads LATENCY-2.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs.ex_mdStart && !hs.ex_branchTaken) begin
          md_stall = 1'b1;
          md_cnt_d = MD_LOAD;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        md_stall = 1'b1;
        if (md_cnt_q != '0) begin
          md_cnt_d = md_cnt_q - MD_CW'(1);
        end else begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`else
  logic unused_md_start;
  assign unused_md_start = hs.ex_mdStart;
  assign md_stall        = 1'b0;
`endif

  logic pc_stall;
  logic ifid_stall;
  logic ifid_flush;
  logic idex_stall;
  logic idex_flush;
  logic exmem_flush;
  logic md_busy;

  // Mul/div occupancy masks load-use; a taken branch squashes ID.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (md_stall) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_flush = 1'b1;
      md_busy     = 1'b1;
    end else if (hs.ex_branchTaken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign hs.pc_stall    = pc_stall;
  assign hs.ifid_stall  = ifid_stall;
  assign hs.ifid_flush  = ifid_flush;
  assign hs.idex_stall  = idex_stall;
  assign hs.idex_flush  = idex_flush;
  assign hs.exmem_flush = exmem_flush;
  assign hs.md_busy     = md_busy;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hs.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a cycle-level reference model.
// Runs with CNT_W=3 so counter saturation is reachable.
module tb_hazard_stall_unit;

  localparam int MD_LAT = 4;
  localparam int CW     = 3;
`ifdef PCPU_MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(CW)) hs ();

  hazard_stall_unit #(
    .MD_LATENCY(MD_LAT),
    .CNT_W     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hs (hs.slave)
  );

  // Reference model: remaining md stall cycles plus a "leaving EX" flag.
  int   m_left = 0;
  bit   m_done = 1'b0;
  int   m_cnt  = 0;
  logic m_lu;
  logic m_md;
  logic e_pc, e_ifs, e_iff, e_ids, e_idf, e_emf, e_mdb;

  always_comb begin
    e_pc = 1'b0; e_ifs = 1'b0; e_iff = 1'b0;
    e_ids = 1'b0; e_idf = 1'b0; e_emf = 1'b0;
    e_mdb = 1'b0;
    m_lu = hs.ex_MemRead && hs.ex_RegWr
        && (hs.ex_Rw != 5'd0)
        && ((hs.id_useRa && hs.id_Ra == hs.ex_Rw)
         || (hs.id_useRb && hs.id_Rb == hs.ex_Rw));
    m_md = MD_EN && ((m_left > 0)
        || (!m_done && hs.ex_mdStart && !hs.ex_branchTaken));
    if (!rst) begin
      if (m_md) begin
        e_pc = 1'b1; e_ifs = 1'b1; e_ids = 1'b1;
        e_emf = 1'b1; e_mdb = 1'b1;
      end else if (hs.ex_branchTaken) begin
        e_iff = 1'b1; e_idf = 1'b1;
      end else if (m_lu) begin
        e_pc = 1'b1; e_ifs = 1'b1; e_idf = 1'b1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      if (m_left > 0) begin
        m_left <= m_left - 1;
        m_done <= (m_left == 1);
      end else if (m_done) begin
        m_done <= 1'b0;
      end else if (MD_EN && hs.ex_mdStart
                   && !hs.ex_branchTaken) begin
        m_left <= MD_LAT - 1;
      end
      if (e_pc && m_cnt < (1 << CW) - 1) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  logic [CW+6:0] got_v;
  logic [CW+6:0] exp_v;
  assign got_v = {hs.pc_stall, hs.ifid_stall, hs.ifid_flush,
                  hs.idex_stall, hs.idex_flush, hs.exmem_flush,
                  hs.md_busy, hs.stall_cnt};
  assign exp_v = {e_pc, e_ifs, e_iff, e_ids, e_idf, e_emf,
                  e_mdb, CW'(m_cnt)};

  always @(negedge clk) begin
    checks = checks + 1;
    if (got_v === exp_v) begin
      passed = passed + 1;
    end else begin
      $display("FAIL model t=%0t got=%b exp=%b",
               $time, got_v, exp_v);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (got === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] ra, input logic [4:0] rb,
                        input logic ua, input logic ub,
                        input logic [4:0] rw, input logic wr,
                        input logic mr, input logic br,
                        input logic md);
    hs.id_Ra = ra; hs.id_Rb = rb;
    hs.id_useRa = ua; hs.id_useRb = ub;
    hs.ex_Rw = rw; hs.ex_RegWr = wr;
    hs.ex_MemRead = mr; hs.ex_branchTaken = br;
    hs.ex_mdStart = md;
  endtask

  task automatic step(input logic [4:0] ra, input logic [4:0] rb,
                      input logic ua, input logic ub,
                      input logic [4:0] rw, input logic wr,
                      input logic mr, input logic br,
                      input logic md);
    @(posedge clk);
    #1;
    set_in(ra, rb, ua, ub, rw, wr, mr, br, md);
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_cnt", 32'(hs.stall_cnt), 0);
    chk("rst_pc", 32'(hs.pc_stall), 0);

    // Load-use on Ra, then the load moves on to MEM
    step(8, 0, 1, 0, 8, 1, 1, 0, 0);
    chk("lu_pc", 32'(hs.pc_stall), 1);
    chk("lu_ifid", 32'(hs.ifid_stall), 1);
    chk("lu_idexf", 32'(hs.idex_flush), 1);
    chk("lu_idexs", 32'(hs.idex_stall), 0);
    step(8, 0, 1, 0, 9, 1, 0, 0, 0);
    chk("lu_after", 32'(hs.pc_stall), 0);
    chk("lu_cnt", 32'(hs.stall_cnt), 1);

    // $0 never hazards; an unused Rb match never hazards
    step(0, 0, 1, 0, 0, 1, 1, 0, 0);
    chk("r0_pc", 32'(hs.pc_stall), 0);
    step(3, 5, 1, 0, 5, 1, 1, 0, 0);
    chk("ub0_pc", 32'(hs.pc_stall), 0);
    step(3, 5, 1, 1, 5, 1, 1, 0, 0);
    chk("rb_pc", 32'(hs.pc_stall), 1);

    // Branch beats load-use
    step(8, 0, 1, 0, 8, 1, 1, 1, 0);
    chk("br_pc", 32'(hs.pc_stall), 0);
    chk("br_ifidf", 32'(hs.ifid_flush), 1);
    chk("br_idexf", 32'(hs.idex_flush), 1);

    // Mul/div held: 4 stalls, release, then a fresh op
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("md_pc%0d", i), 32'(hs.pc_stall),
          (MD_EN && i != 4) ? 1 : 0);
      if (i == 4) begin
        chk("md_cnt", 32'(hs.stall_cnt), MD_EN ? 4 : 0);
      end
    end
    repeat (5) nop();

    // md + load-use together, then load-use masked while busy
    step(8, 0, 1, 0, 8, 1, 1, 0, 1);
    chk("mdlu_exf", 32'(hs.exmem_flush), MD_EN ? 1 : 0);
    step(8, 0, 1, 0, 8, 1, 1, 0, 0);
    chk("mdbusy_idf", 32'(hs.idex_flush), MD_EN ? 0 : 1);
    repeat (5) nop();

    // Reset in the middle of a stall drops everything at once
    step(8, 0, 1, 0, 8, 1, 1, 0, 1);
    chk("pre_rst_pc", 32'(hs.pc_stall), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", 32'(hs.pc_stall), 0);
    chk("mid_rst_idf", 32'(hs.idex_flush), 0);
    chk("mid_rst_cnt", 32'(hs.stall_cnt), 0);
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    nop();

    // Illegal md + branch: branch wins, no md stall follows
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("mdbr_pc", 32'(hs.pc_stall), 0);
    chk("mdbr_iff", 32'(hs.ifid_flush), 1);
    nop();
    chk("mdbr_next", 32'(hs.pc_stall), 0);

    // Counter saturation at 2^3-1
    rst_pulse();
    for (int i = 0; i < 10; i++) begin
      step(4, 0, 1, 0, 4, 1, 1, 0, 0);
    end
    chk("sat_pc", 32'(hs.pc_stall), 1);
    nop();
    chk("sat_cnt", 32'(hs.stall_cnt), 7);
    nop();
    chk("sat_hold", 32'(hs.stall_cnt), 7);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
